mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ADDR_W, default 8: width of the write address and of the address counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  byte-stream source has a valid byte on in_data.
REQ-005 in_data  input  8  byte-stream data.
REQ-006 in_ready  output  1  loader accepts in_data this cycle.
REQ-007 wr_inst  output  1  one-cycle write strobe to the instruction memory.
REQ-008 wr_dado  output  1  one-cycle write strobe to the data memory.
REQ-009 wr_addr  output  ADDR_W  write address.
REQ-010 wr_data  output  8  write data.
REQ-011 cpu_hold  output  1  holds the processor in reset while high.
REQ-012 done  output  1  load completed successfully.
REQ-013 error  output  1  malformed frame or checksum failure.

Function
REQ-014 A byte transfers only on a rising edge with in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-015 Frame layout: CMD, ADDR, LEN, then LEN payload bytes (LEN=0 means 256); CMD bit7 selects the target (0=instruction, 1=data), CMD bit6 marks the last frame, and CMD bits5:0 are reserved and must be 0.
REQ-016 The FSM states are IDLE, CMD, ADDR, LEN, DATA, (CSUM), DONE and ERR.
REQ-017 IDLE->CMD occurs on the first clock after reset release, and in_ready=0 in IDLE.
REQ-018 CMD->ADDR on accept when bits5:0=0, otherwise CMD->ERR.
REQ-019 ADDR->LEN on accept; the accepted byte loads the address counter, zero-extended or truncated to ADDR_W.
REQ-020 LEN->DATA on accept; the accepted byte loads the remaining count (0 loads 256).
REQ-021 In DATA, each accepted byte causes exactly one write strobe on the next cycle, with wr_addr equal to the counter and wr_data equal to the byte; the counter then increments and the remaining count decrements.
REQ-022 The write latency is exactly 1 cycle from accept to strobe, and wr_inst and wr_dado are never high together.
REQ-023 The address counter wraps from 2^ADDR_W-1 to 0 without error.
REQ-024 After the final payload byte, the FSM moves to DONE if the last flag is set, otherwise back to CMD (or to CSUM when checksum is enabled).
REQ-025 in_ready=1 only in CMD, ADDR, LEN, DATA and CSUM, and back-pressure is never asserted mid-frame.
REQ-026 In DONE: done=1, cpu_hold=0, in_ready=0, no strobes; DONE is held until reset.
REQ-027 In ERR: error=1, cpu_hold=1, in_ready=0, no strobes; ERR is held until reset.
REQ-028 cpu_hold falls on the same edge that enters DONE, and the final write strobe occurs on that same edge cycle or earlier.
REQ-029 Idle gaps (in_valid=0) in any receiving state leave state, counters and outputs unchanged, and strobes are 0.

Reset
REQ-030 When reset=0, the FSM goes to IDLE immediately, independent of clk.
REQ-031 Reset values: in_ready=0, wr_inst=0, wr_dado=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0.
REQ-032 A reset mid-frame discards the partial frame, and a pending write strobe is suppressed.

Configuration
REQ-033 With macro MEM_LOADER_CHECKSUM_EN defined, each frame carries one trailing byte after the payload, equal to the 8-bit two's-complement negation of the mod-256 sum of CMD, ADDR, LEN and the payload bytes.
REQ-034 With MEM_LOADER_CHECKSUM_EN defined, a matching checksum byte moves CSUM to CMD or DONE; a mismatch moves CSUM to ERR, and writes already issued are not undone.
REQ-035 Without MEM_LOADER_CHECKSUM_EN, the CSUM state and the checksum accumulator do not exist, and frames carry no checksum byte.

Verification
REQ-036 Frame 0x40,0x00,0x03,0x11,0x22,0x33 -> wr_inst strobes at addresses 0,1,2 with data 0x11,0x22,0x33; then done=1 and cpu_hold=0.
REQ-037 Frame 0x00,0x10,0x01,0xA5 followed by 0xC0,0x03,0x02,0x05,0x09 -> wr_inst at 0x10=0xA5, then wr_dado at 0x03=0x05 and 0x04=0x09, then done=1.
REQ-038 Frame 0xC0,0xFF,0x02,0x01,0x02 -> wr_dado at 0xFF=0x01 then 0x00=0x02, with no error.
REQ-039 CMD byte 0x41 -> error=1, in_ready=0, no strobes, cpu_hold=1 until reset.
REQ-040 in_valid toggled 1/0 every cycle during the 0x40,0x00,0x02,0xAA,0xBB frame -> same writes as gap-free, each strobe exactly 1 cycle after its accept.
REQ-041 reset pulsed low after the second payload byte of a 4-byte frame, then the full frame resent -> outputs return to reset values; no strobe for the third byte before reset; done=1 after the resend; (checksum build: a wrong checksum byte on frame 0x40,0x00,0x01,0x7F -> error=1).

Source files
------------

// File: rtl/mem_loader.sv
// Frame-based byte-stream loader: writes instruction/data memories while holding the CPU in reset.
// Define MEM_LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte per frame.
module mem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_inst,
   output logic              wr_dado,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_LEN  = 3'd3,
      ST_DATA = 3'd4,
`ifdef MEM_LOADER_CHECKSUM_EN
      ST_CSUM = 3'd5,
`endif
      ST_DONE = 3'd6,
      ST_ERR  = 3'd7
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic              accept_s;
   logic              data_wr_s;
   logic              ready_next_s;
   logic [ADDR_W-1:0] addr_load_s;
   logic [8:0]        len_load_s;
   logic [ADDR_W-1:0] addr_cnt_r;
   logic [8:0]        rem_r;
   logic              target_r;
   logic              last_r;
   logic              in_ready_r;
   logic              wr_inst_r;
   logic              wr_dado_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [7:0]        wr_data_r;
   logic              cpu_hold_r;
   logic              done_r;
   logic              error_r;

`ifdef MEM_LOADER_CHECKSUM_EN
   logic [7:0]        sum_r;

   // A frame is good when the running sum plus the checksum byte wraps to zero.
   function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] chk);
      logic [7:0] total;
      total = sum + chk;
      return (total == 8'd0);
   endfunction
`endif

   // Operand shaping for the address and length loads.
   always_comb begin
      addr_load_s = ADDR_W'(in_data);
      if (in_data == 8'd0) begin
         len_load_s = 9'd256;
      end else begin
         len_load_s = {1'b0, in_data};
      end
   end

   // Next-state decode and transfer qualification.
   always_comb begin
      state_next_s = state_r;
      accept_s     = in_valid && in_ready_r;
      data_wr_s    = 1'b0;
      case (state_r)
         ST_IDLE: state_next_s = ST_CMD;
         ST_CMD: begin
            if (accept_s) begin
               if (in_data[5:0] == 6'd0) begin
                  state_next_s = ST_ADDR;
               end else begin
                  state_next_s = ST_ERR;
               end
            end else begin
               state_next_s = state_r;
            end
         end
         ST_ADDR: begin
            if (accept_s) begin
               state_next_s = ST_LEN;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_LEN: begin
            if (accept_s) begin
               state_next_s = ST_DATA;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
               data_wr_s = 1'b1;
               if (rem_r == 9'd1) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                  state_next_s = ST_CSUM;
`else
                  state_next_s = last_r ? ST_DONE : ST_CMD;
`endif
               end else begin
                  state_next_s = state_r;
               end
            end else begin
               state_next_s = state_r;
            end
         end
`ifdef MEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (accept_s) begin
               if (csum_ok(sum_r, in_data)) begin
                  state_next_s = last_r ? ST_DONE : ST_CMD;
               end else begin
                  state_next_s = ST_ERR;
               end
            end else begin
               state_next_s = state_r;
            end
         end
`endif
         ST_DONE: state_next_s = ST_DONE;
         ST_ERR:  state_next_s = ST_ERR;
         default: state_next_s = ST_ERR;
      endcase
`ifdef MEM_LOADER_CHECKSUM_EN
      ready_next_s = state_next_s inside {ST_CMD, ST_ADDR, ST_LEN, ST_DATA, ST_CSUM};
`else
      ready_next_s = state_next_s inside {ST_CMD, ST_ADDR, ST_LEN, ST_DATA};
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Datapath and registered outputs; status flags follow the next state so they change on entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_cnt_r <= '0;
         rem_r      <= 9'd0;
         target_r   <= 1'b0;
         last_r     <= 1'b0;
         in_ready_r <= 1'b0;
         wr_inst_r  <= 1'b0;
         wr_dado_r  <= 1'b0;
         wr_addr_r  <= '0;
         wr_data_r  <= 8'd0;
         cpu_hold_r <= 1'b1;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         in_ready_r <= ready_next_s;
         cpu_hold_r <= (state_next_s != ST_DONE);
         done_r     <= (state_next_s == ST_DONE);
         error_r    <= (state_next_s == ST_ERR);
         wr_inst_r  <= data_wr_s && !target_r;
         wr_dado_r  <= data_wr_s && target_r;
         if (accept_s && (state_r == ST_CMD)) begin
            target_r <= in_data[7];
            last_r   <= in_data[6];
         end
         if (accept_s && (state_r == ST_ADDR)) begin
            addr_cnt_r <= addr_load_s;
         end
         if (accept_s && (state_r == ST_LEN)) begin
            rem_r <= len_load_s;
         end
         if (data_wr_s) begin
            wr_addr_r  <= addr_cnt_r;
            wr_data_r  <= in_data;
            addr_cnt_r <= addr_cnt_r + ADDR_W'(1'b1);
            rem_r      <= rem_r - 9'd1;
         end
      end
   end

`ifdef MEM_LOADER_CHECKSUM_EN
   // Running mod-256 sum of header and payload bytes, restarted by each CMD byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_r <= 8'd0;
      end else if (accept_s && (state_r == ST_CMD)) begin
         sum_r <= in_data;
      end else if (accept_s && (state_r inside {ST_ADDR, ST_LEN, ST_DATA})) begin
         sum_r <= sum_r + in_data;
      end else begin
         sum_r <= sum_r;
      end
   end
`endif

   assign in_ready = in_ready_r;
   assign wr_inst  = wr_inst_r;
   assign wr_dado  = wr_dado_r;
   assign wr_addr  = wr_addr_r;
   assign wr_data  = wr_data_r;
   assign cpu_hold = cpu_hold_r;
   assign done     = done_r;
   assign error    = error_r;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a driver pushes expected writes into a scoreboard queue and a
// negedge monitor pops and compares each strobe, including its cycle relative to the accept.
module tb_mem_loader;

   typedef struct {
      logic       tgt;
      logic [7:0] addr;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       wr_inst;
   logic       wr_dado;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       cpu_hold;
   logic       done;
   logic       error;

   exp_t       exp_q[$];
   logic [7:0] pay_q[$];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   mem_loader #(.ADDR_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_inst  (wr_inst),
      .wr_dado  (wr_dado),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Scoreboard: every visible strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1 && (wr_inst === 1'b1 || wr_dado === 1'b1)) begin
         chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("strobe_inst", 32'(wr_inst), 32'(!e.tgt));
            chk("strobe_dado", 32'(wr_dado), 32'(e.tgt));
            chk("strobe_addr", 32'(wr_addr), 32'(e.addr));
            chk("strobe_data", 32'(wr_data), 32'(e.data));
            chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit pay, input bit tgt, input logic [7:0] a);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", 32'(n < 20), 32'd1);
      if (n < 20 && pay) begin
         e.tgt  = tgt;
         e.addr = a;
         e.data = b;
         e.cyc  = cyc + 1;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic gap_cycle(input bit g);
      if (g) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input bit gap);
      logic [7:0] len;
      logic [7:0] sum;
      int         n;
      n   = pay_q.size();
      len = 8'(n);
      sum = cmd + addr + len;
      send_byte(cmd, 1'b0, 1'b0, 8'h00);
      gap_cycle(gap);
      send_byte(addr, 1'b0, 1'b0, 8'h00);
      gap_cycle(gap);
      send_byte(len, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < n; i++) begin
         gap_cycle(gap);
         send_byte(pay_q[i], 1'b1, cmd[7], addr + 8'(i));
         sum = sum + pay_q[i];
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      gap_cycle(gap);
      send_byte(8'(8'h00 - sum), 1'b0, 1'b0, 8'h00);
`endif
      chk("frame_done", 32'(done), 32'(cmd[6]));
      chk("frame_hold", 32'(cpu_hold), 32'(!cmd[6]));
      pay_q.delete();
   endtask

   task automatic finish_check(input string tag);
      repeat (2) @(negedge clk);
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_error"}, 32'(error), 32'd0);
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      in_valid = 1'b0;
      reset    = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_inst", 32'(wr_inst), 32'd0);
      chk("rst_dado", 32'(wr_dado), 32'd0);
      chk("rst_addr", 32'(wr_addr), 32'd0);
      chk("rst_data", 32'(wr_data), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      reset = 1'b1;
      chk("idle_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("cmd_ready", 32'(in_ready), 32'd1);

      // Single last instruction frame.
      pay_q = '{8'h11, 8'h22, 8'h33};
      send_frame(8'h40, 8'h00, 1'b0);
      finish_check("single");

      // Instruction frame then last data frame.
      do_reset();
      pay_q = '{8'hA5};
      send_frame(8'h00, 8'h10, 1'b0);
      chk("mid_ready", 32'(in_ready), 32'd1);
      pay_q = '{8'h05, 8'h09};
      send_frame(8'hC0, 8'h03, 1'b0);
      finish_check("two_frame");

      // Address counter wrap.
      do_reset();
      pay_q = '{8'h01, 8'h02};
      send_frame(8'hC0, 8'hFF, 1'b0);
      finish_check("wrap");

      // Idle gap between every byte.
      do_reset();
      pay_q = '{8'hAA, 8'hBB};
      send_frame(8'h40, 8'h00, 1'b1);
      finish_check("gaps");

      // Reserved CMD bits set.
      do_reset();
      send_byte(8'h41, 1'b0, 1'b0, 8'h00);
      chk("bad_cmd_error", 32'(error), 32'd1);
      chk("bad_cmd_ready", 32'(in_ready), 32'd0);
      chk("bad_cmd_hold", 32'(cpu_hold), 32'd1);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h00;
      repeat (4) @(negedge clk);
      chk("err_held", 32'(error), 32'd1);
      chk("err_hold_cpu", 32'(cpu_hold), 32'd1);
      chk("err_done", 32'(done), 32'd0);
      in_valid = 1'b0;

      // Reset mid-frame, then resend.
      do_reset();
      send_byte(8'h40, 1'b0, 1'b0, 8'h00);
      send_byte(8'h00, 1'b0, 1'b0, 8'h00);
      send_byte(8'h04, 1'b0, 1'b0, 8'h00);
      send_byte(8'h01, 1'b1, 1'b0, 8'h00);
      send_byte(8'h02, 1'b1, 1'b0, 8'h01);
      @(negedge clk);
      #2;
      in_valid = 1'b1;
      in_data  = 8'h03;
      reset    = 1'b0;
      #1;
      chk("midrst_ready", 32'(in_ready), 32'd0);
      chk("midrst_inst", 32'(wr_inst), 32'd0);
      chk("midrst_addr", 32'(wr_addr), 32'd0);
      chk("midrst_data", 32'(wr_data), 32'd0);
      chk("midrst_hold", 32'(cpu_hold), 32'd1);
      chk("midrst_drained", 32'(exp_q.size()), 32'd0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(8'h40, 8'h00, 1'b0);
      finish_check("resend");

`ifdef MEM_LOADER_CHECKSUM_EN
      // Wrong checksum byte: the write stands, the load fails.
      do_reset();
      send_byte(8'h40, 1'b0, 1'b0, 8'h00);
      send_byte(8'h00, 1'b0, 1'b0, 8'h00);
      send_byte(8'h01, 1'b0, 1'b0, 8'h00);
      send_byte(8'h7F, 1'b1, 1'b0, 8'h00);
      send_byte(8'h00, 1'b0, 1'b0, 8'h00);
      chk("csum_error", 32'(error), 32'd1);
      chk("csum_done", 32'(done), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
